// File: rtl/copro_alu_sched.sv
// Issue scheduler and in-order result FIFO in front of the single-cycle copro_alu.
// A FIFO slot is reserved at dispatch, so ALU results are never lost to result backpressure.
package copro_alu_pkg;
  typedef enum logic [3:0] {
    NOP        = 4'd0,
    ADD        = 4'd1,
    DOUBLE_RS1 = 4'd2,
    DOUBLE_RS2 = 4'd3,
    ADD_MULTI  = 4'd4
  } opcode_t;
endpackage

module copro_alu_sched
  import copro_alu_pkg::*;
#(
  parameter int unsigned NrRgprPorts = 2,
  parameter int unsigned DEPTH       = 4,
  parameter type         hartid_t    = logic,
  parameter type         id_t        = logic,
  parameter type         registers_t = logic [NrRgprPorts-1:0][63:0]
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        issue_valid_i,
  output logic        issue_ready_o,
  input  opcode_t     opcode_i,
  input  registers_t  registers_i,
  input  hartid_t     hartid_i,
  input  id_t         id_i,
  input  logic [4:0]  rd_i,
  output opcode_t     alu_opcode_o,
  output registers_t  alu_registers_o,
  output hartid_t     alu_hartid_o,
  output id_t         alu_id_o,
  output logic [4:0]  alu_rd_o,
  input  logic [63:0] alu_result_i,
  input  hartid_t     alu_hartid_i,
  input  id_t         alu_id_i,
  input  logic [4:0]  alu_rd_i,
  input  logic        alu_valid_i,
  input  logic        alu_we_i,
  output logic        result_valid_o,
  input  logic        result_ready_i,
  output logic [63:0] result_data_o,
  output hartid_t     result_hartid_o,
  output id_t         result_id_o,
  output logic [4:0]  result_rd_o,
  output logic        result_we_o,
  output logic [7:0]  drop_cnt_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          inflight_q;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [7:0]    drop_q, drop_d;
  logic [CW:0]   occupancy;

  logic [63:0]   data_q   [DEPTH];
  hartid_t       hartid_q [DEPTH];
  id_t           id_q     [DEPTH];
  logic [4:0]    rd_q     [DEPTH];
  logic          we_q     [DEPTH];

  logic dispatch, push, pop, drop;

  // Pointers wrap explicitly because DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Credit check covers the op still in the ALU, so its result always has a slot.
  assign occupancy     = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign issue_ready_o = occupancy < (CW+1)'(DEPTH);

  assign dispatch       = issue_valid_i & issue_ready_o;
  assign push           = inflight_q & alu_valid_i;
  assign drop           = inflight_q & ~alu_valid_i;
  assign result_valid_o = (count_q != '0);
  assign pop            = result_valid_o & result_ready_i;

  always_comb begin
    alu_opcode_o    = NOP;
    alu_registers_o = '0;
    alu_hartid_o    = '0;
    alu_id_o        = '0;
    alu_rd_o        = '0;
    if (dispatch) begin
      alu_opcode_o    = opcode_i;
      alu_registers_o = registers_i;
      alu_hartid_o    = hartid_i;
      alu_id_o        = id_i;
      alu_rd_o        = rd_i;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    drop_d  = drop_q;
    if (push) wptr_d = ptr_inc(wptr_q);
    if (pop)  rptr_d = ptr_inc(rptr_q);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= 1'b0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      drop_q     <= '0;
    end else begin
      inflight_q <= dispatch;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      drop_q     <= drop_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i]   <= '0;
        hartid_q[i] <= '0;
        id_q[i]     <= '0;
        rd_q[i]     <= '0;
        we_q[i]     <= 1'b0;
      end
    end else if (push) begin
      data_q[wptr_q]   <= alu_result_i;
      hartid_q[wptr_q] <= alu_hartid_i;
      id_q[wptr_q]     <= alu_id_i;
      rd_q[wptr_q]     <= alu_rd_i;
      we_q[wptr_q]     <= alu_we_i;
    end
  end

  assign result_data_o   = data_q[rptr_q];
  assign result_hartid_o = hartid_q[rptr_q];
  assign result_id_o     = id_q[rptr_q];
  assign result_rd_o     = rd_q[rptr_q];
  assign result_we_o     = we_q[rptr_q];
  assign drop_cnt_o      = drop_q;

endmodule

// File: tb/tb_copro_alu_sched.sv
// Bench for copro_alu_sched with DEPTH=3: directed steps plus random traffic,
// checked every cycle against a queue model of outstanding operations.
module tb_copro_alu_sched;
  import copro_alu_pkg::*;

  typedef logic [1:0]       hart_t;
  typedef logic [3:0]       tid_t;
  typedef logic [1:0][63:0] regs_t;
  localparam int DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_ready;
  opcode_t     op_in;
  regs_t       regs_in;
  hart_t       hart_in;
  tid_t        id_in;
  logic [4:0]  rd_in;
  opcode_t     alu_op;
  regs_t       alu_regs;
  hart_t       alu_hart_o;
  tid_t        alu_id_o;
  logic [4:0]  alu_rd_o;
  logic [63:0] alu_res;
  hart_t       alu_hart_r;
  tid_t        alu_id_r;
  logic [4:0]  alu_rd_r;
  logic        alu_vld, alu_we;
  logic        res_valid, res_ready;
  logic [63:0] res_data;
  hart_t       res_hart;
  tid_t        res_id;
  logic [4:0]  res_rd;
  logic        res_we;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int drop_done = 0;
  int n_pop = 0;
  int n_disp = 0;
  int rdy_mode = 0;

  typedef struct {
    int          dcyc;
    bit          vld;
    logic [63:0] data;
    hart_t       hart;
    tid_t        id;
    logic [4:0]  rd;
    logic        we;
  } rec_t;
  rec_t mq[$];

  copro_alu_sched #(
    .NrRgprPorts(2), .DEPTH(DEPTH), .hartid_t(hart_t), .id_t(tid_t), .registers_t(regs_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .opcode_i(op_in), .registers_i(regs_in), .hartid_i(hart_in), .id_i(id_in), .rd_i(rd_in),
    .alu_opcode_o(alu_op), .alu_registers_o(alu_regs), .alu_hartid_o(alu_hart_o),
    .alu_id_o(alu_id_o), .alu_rd_o(alu_rd_o),
    .alu_result_i(alu_res), .alu_hartid_i(alu_hart_r), .alu_id_i(alu_id_r),
    .alu_rd_i(alu_rd_r), .alu_valid_i(alu_vld), .alu_we_i(alu_we),
    .result_valid_o(res_valid), .result_ready_i(res_ready), .result_data_o(res_data),
    .result_hartid_o(res_hart), .result_id_o(res_id), .result_rd_o(res_rd),
    .result_we_o(res_we), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit op_legal(input opcode_t op);
    return op inside {ADD, DOUBLE_RS1, DOUBLE_RS2, ADD_MULTI};
  endfunction

  function automatic logic [63:0] alu_fn(input opcode_t op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      ADD, ADD_MULTI: return a + b;
      DOUBLE_RS1:     return a + a;
      DOUBLE_RS2:     return b + b;
      default:        return 64'd0;
    endcase
  endfunction

  // Stand-in for copro_alu: one registered stage, valid only for supported opcodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_vld <= 1'b0; alu_res <= '0; alu_we <= 1'b0;
      alu_hart_r <= '0; alu_id_r <= '0; alu_rd_r <= '0;
    end else begin
      alu_vld    <= op_legal(alu_op);
      alu_res    <= alu_fn(alu_op, alu_regs[0], alu_regs[1]);
      alu_we     <= op_legal(alu_op) && (alu_op != ADD_MULTI);
      alu_hart_r <= alu_hart_o;
      alu_id_r   <= alu_id_o;
      alu_rd_r   <= alu_rd_o;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle model: an op holds a credit from the cycle after dispatch until it is
  // popped (legal) or for exactly that one cycle (unsupported); results show 2 cycles on.
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      drop_done = 0;
      chk("rst_ready", 64'(issue_ready), 64'd1);
      chk("rst_valid", 64'(res_valid), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);
      chk("rst_data", res_data, 64'd0);
      chk("rst_hart", 64'(res_hart), 64'd0);
      chk("rst_id", 64'(res_id), 64'd0);
      chk("rst_rd", 64'(res_rd), 64'd0);
      chk("rst_we", 64'(res_we), 64'd0);
      chk("rst_alu_op", 64'(alu_op), 64'(NOP));
    end else begin
      int h;
      bit ev;
      rec_t r;
      for (int i = mq.size() - 1; i >= 0; i--)
        if (!mq[i].vld && mq[i].dcyc < cyc - 1) begin
          mq.delete(i);
          drop_done++;
        end
      chk("ready", 64'(issue_ready), 64'(mq.size() < DEPTH));
      h = -1;
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].vld) begin h = i; break; end
      ev = (h >= 0) && (mq[h].dcyc <= cyc - 2);
      chk("valid", 64'(res_valid), 64'(ev));
      if (ev && res_valid) begin
        chk("head_data", res_data, mq[h].data);
        chk("head_hart", 64'(res_hart), 64'(mq[h].hart));
        chk("head_id", 64'(res_id), 64'(mq[h].id));
        chk("head_rd", 64'(res_rd), 64'(mq[h].rd));
        chk("head_we", 64'(res_we), 64'(mq[h].we));
      end
      chk("drop_cnt", 64'(drop_cnt), 64'((drop_done > 255) ? 255 : drop_done));
      if (issue_valid && issue_ready) begin
        chk("alu_op", 64'(alu_op), 64'(op_in));
        chk("alu_rs1", alu_regs[0], regs_in[0]);
        chk("alu_rs2", alu_regs[1], regs_in[1]);
        chk("alu_id", 64'(alu_id_o), 64'(id_in));
        chk("alu_rd", 64'(alu_rd_o), 64'(rd_in));
        chk("alu_hart", 64'(alu_hart_o), 64'(hart_in));
      end else begin
        chk("alu_idle_op", 64'(alu_op), 64'(NOP));
        chk("alu_idle_rs", alu_regs[0] | alu_regs[1], 64'd0);
        chk("alu_idle_id", 64'({alu_id_o, alu_rd_o, alu_hart_o}), 64'd0);
      end
      if (dut.inflight_q && alu_vld) chk("push_room", 64'(dut.count_q < DEPTH), 64'd1);
      chk("count_max", 64'(dut.count_q <= DEPTH), 64'd1);
      if (res_valid && res_ready && ev) begin
        mq.delete(h);
        n_pop++;
      end
      if (issue_valid && issue_ready) begin
        r.dcyc = cyc;
        r.vld  = op_legal(op_in);
        r.data = alu_fn(op_in, regs_in[0], regs_in[1]);
        r.hart = hart_in;
        r.id   = id_in;
        r.rd   = rd_in;
        r.we   = (op_in != ADD_MULTI);
        mq.push_back(r);
        n_disp++;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    case (rdy_mode)
      1: res_ready = ~res_ready;
      2: res_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  endtask

  task automatic set_issue(input opcode_t op, input logic [63:0] a, input logic [63:0] b,
                           input tid_t id, input logic [4:0] rd, input hart_t h);
    issue_valid = 1'b1;
    op_in = op; regs_in[0] = a; regs_in[1] = b;
    id_in = id; rd_in = rd; hart_in = h;
  endtask

  task automatic wait_accept(output int n);
    bit acc;
    acc = 1'b0;
    n = 0;
    while (!acc) begin
      @(negedge clk);
      acc = issue_ready;
      step();
      n++;
      if (!acc && n > 200) begin
        checks++;
        errors++;
        $error("FAIL accept_timeout observed=stalled expected=accepted");
        break;
      end
    end
    issue_valid = 1'b0;
  endtask

  task automatic issue_op(input opcode_t op, input logic [63:0] a, input logic [63:0] b,
                          input tid_t id, input logic [4:0] rd, input hart_t h, output int n);
    set_issue(op, a, b, id, rd, h);
    wait_accept(n);
  endtask

  initial begin
    int n, stalls, base;
    opcode_t rop;
    rst_n = 1'b0; issue_valid = 1'b0; res_ready = 1'b1;
    op_in = NOP; regs_in = '0; hart_in = '0; id_in = '0; rd_in = '0;
    repeat (3) step();
    @(negedge clk);
    chk("reset_ready", 64'(issue_ready), 64'd1);
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // Single ADD: result two cycles after dispatch.
    issue_op(ADD, 64'd5, 64'd7, 4'd3, 5'd9, 2'd1, n);
    @(negedge clk);
    chk("add_t1_valid", 64'(res_valid), 64'd0);
    step();
    @(negedge clk);
    chk("add_t2_valid", 64'(res_valid), 64'd1);
    chk("add_data", res_data, 64'd12);
    chk("add_id", 64'(res_id), 64'd3);
    chk("add_rd", 64'(res_rd), 64'd9);
    chk("add_we", 64'(res_we), 64'd1);
    repeat (3) step();

    // Back-to-back stream with an always-ready consumer.
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      issue_op(ADD, 64'(i * 3), 64'(100 + i), tid_t'(i), 5'(i + 1), 2'd0, n);
      stalls += n - 1;
    end
    chk("stream_stalls", 64'(stalls), 64'd0);
    repeat (5) step();

    // Backpressure until the credits run out, then drain.
    res_ready = 1'b0;
    base = n_disp;
    for (int i = 0; i < DEPTH; i++) issue_op(ADD, 64'(i), 64'd1, tid_t'(i), 5'd2, 2'd2, n);
    set_issue(ADD, 64'd3, 64'd1, 4'd3, 5'd2, 2'd2);
    repeat (6) step();
    @(negedge clk);
    chk("bp_accepted", 64'(n_disp - base), 64'(DEPTH));
    chk("bp_ready_low", 64'(issue_ready), 64'd0);
    res_ready = 1'b1;
    wait_accept(n);
    for (int i = 4; i < 6; i++) issue_op(ADD, 64'(i), 64'd1, tid_t'(i), 5'd2, 2'd2, n);
    repeat (6) step();
    chk("bp_all_accepted", 64'(n_disp - base), 64'd6);

    // Alternating ready with random operands; exercises simultaneous push/pop and wrap.
    rdy_mode = 1;
    for (int i = 0; i < 20; i++)
      issue_op(ADD, {$urandom, $urandom}, {$urandom, $urandom}, tid_t'(i), 5'($urandom),
               hart_t'($urandom), n);
    rdy_mode = 0; res_ready = 1'b1;
    repeat (6) step();

    // Unsupported opcode between two ADDs.
    base = n_pop;
    issue_op(ADD, 64'd1, 64'd2, 4'd10, 5'd1, 2'd0, n);
    issue_op(opcode_t'(4'hE), 64'd3, 64'd4, 4'd11, 5'd2, 2'd0, n);
    issue_op(ADD, 64'd5, 64'd6, 4'd12, 5'd3, 2'd0, n);
    repeat (6) step();
    @(negedge clk);
    chk("illegal_pops", 64'(n_pop - base), 64'd2);
    chk("illegal_drop", 64'(drop_cnt), 64'd1);
    chk("illegal_ready", 64'(issue_ready), 64'd1);
    step();

    // Reset while results are buffered and one op is in flight.
    res_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) issue_op(ADD, 64'(i), 64'd9, tid_t'(i), 5'd4, 2'd3, n);
    chk("pre_rst_valid", 64'(res_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(res_valid), 64'd0);
    chk("midrst_drop", 64'(drop_cnt), 64'd0);
    chk("midrst_ready", 64'(issue_ready), 64'd1);
    chk("midrst_data", res_data, 64'd0);
    step(); step();
    rst_n = 1'b1;
    res_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("post_rst_valid", 64'(res_valid), 64'd0);
    step();

    // Random traffic: gaps, mixed opcodes, random consumer readiness.
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) step();
      case ($urandom_range(0, 9))
        0: rop = opcode_t'(4'hD);
        1: rop = DOUBLE_RS1;
        2: rop = DOUBLE_RS2;
        3: rop = ADD_MULTI;
        default: rop = ADD;
      endcase
      issue_op(rop, {$urandom, $urandom}, {$urandom, $urandom}, tid_t'(i), 5'($urandom),
               hart_t'($urandom), n);
    end
    rdy_mode = 0; res_ready = 1'b1;
    repeat (8) step();

    // Drop counter saturation.
    for (int i = 0; i < 260; i++) issue_op(opcode_t'(4'hF), 64'd0, 64'd0, 4'd0, 5'd0, 2'd0, n);
    repeat (4) step();
    @(negedge clk);
    chk("drop_saturate", 64'(drop_cnt), 64'd255);
    chk("final_ready", 64'(issue_ready), 64'd1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
